// File: rtl/mem_wait_responder.sv
// mem_wait_responder: single-outstanding word memory responder with a fixed
// number of wait states, byte-lane writes and misaligned/out-of-range error
// reporting. Accesses are serialized: IDLE -> BUSY (wait) -> RESP -> IDLE.
module mem_wait_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_ready;
    logic           r_err;
    logic [31:0]    r_rdata;

    // Request copies captured at acceptance; the live inputs are ignored after that.
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_be;

    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_accept;
    logic           w_perform;
    logic           w_err;
    logic           w_do_write;
    logic [AW-1:0]  w_idx;
    logic [31:0]    w_rd_word;

    assign w_accept   = (r_state == S_IDLE) && req;
    assign w_perform  = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_err      = (r_addr[1:0] != 2'b00) ||
                        ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_do_write = w_perform && r_we && !w_err;
    assign w_idx      = r_addr[AW+1:2];
    assign w_rd_word  = r_mem[w_idx];

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;
    assign busy  = (r_state != S_IDLE);

    // Latch the request fields on the accepting edge (data path, no reset).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= be;
        end
    end

    // Sequencer: wait-state countdown, access, one-cycle registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_cnt   <= CW'(WAIT_CYCLES);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_err   <= w_err;
                        // Writes and errored accesses return zero data.
                        r_rdata <= (w_err || r_we) ? 32'h0 : w_rd_word;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-lane array update; the array is never reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Bench for mem_wait_responder: a WAIT_CYCLES=2 instance checked every cycle
// against a transaction-timeline model, plus a WAIT_CYCLES=0 instance used
// for back-to-back throughput checks. Directed literals pin the model.
module tb_mem_wait_responder;

    localparam int DEPTH = 1024;
    localparam int W2    = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // WAIT_CYCLES=2 instance signals
    logic        req2 = 1'b0, we2 = 1'b0;
    logic [31:0] addr2 = '0, wdata2 = '0;
    logic [3:0]  be2 = '0;
    logic [31:0] rdata2;
    logic        ready2, err2, busy2;

    // WAIT_CYCLES=0 instance signals
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] rdata0;
    logic        ready0, err0, busy0;

    mem_wait_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2),
        .wdata(wdata2), .be(be2), .rdata(rdata2), .ready(ready2),
        .err(err2), .busy(busy2)
    );

    mem_wait_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .be(be0), .rdata(rdata0), .ready(ready0),
        .err(err0), .busy(busy0)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Transaction-timeline model of the WAIT=2 instance ------
    // m_age counts edges since the request was accepted (-1 when idle). The
    // response appears after WAIT+1 edges; the instance is idle again after
    // WAIT+2 edges. Writes land in the model memory when the access happens.
    logic [31:0] mmem [int];
    int          m_age = -1;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        exp_ready = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
    logic [31:0] exp_rdata = '0;
    bit          chk_on = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age = -1;
            exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = '0; exp_busy = 1'b0;
        end else begin
            exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = '0;
            if (m_age < 0) begin
                if (req2) begin
                    m_we = we2; m_addr = addr2; m_wdata = wdata2; m_be = be2;
                    m_age = 0;
                end
            end else begin
                m_age++;
                if (m_age == W2 + 1) begin
                    logic        e;
                    logic [31:0] word;
                    int          a;
                    a = int'(m_addr >> 2);
                    e = (m_addr % 4 != 0) || ((m_addr >> 2) >= DEPTH);
                    word = mmem.exists(a) ? mmem[a] : 32'h0;
                    exp_ready = 1'b1;
                    exp_err = e;
                    if (!e && m_we) begin
                        for (int i = 0; i < 4; i++)
                            if (m_be[i]) word[8*i +: 8] = m_wdata[8*i +: 8];
                        mmem[a] = word;
                    end else if (!e) begin
                        exp_rdata = word;
                    end
                end else if (m_age == W2 + 2) begin
                    m_age = -1;
                end
            end
            exp_busy = (m_age >= 0);
        end
    end

    // Cycle-by-cycle comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_ready", 32'(ready2), 32'(exp_ready));
            chk("model_busy", 32'(busy2), 32'(exp_busy));
            if (exp_ready) begin
                chk("model_err", 32'(err2), 32'(exp_err));
                chk("model_rdata", rdata2, exp_rdata);
            end
        end
    end

    // ---------------- Directed request helpers --------------------------------
    // Issue one request to the WAIT=2 instance from a negedge; returns the data,
    // error and number of edges from the accepting edge to the sampling edge.
    task automatic do_req2(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, output logic [31:0] rd,
                           output logic er, output int lat);
        int n;
        req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; be2 = b;
        n = 0; rd = 'x; er = 1'bx; lat = -1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ready2) begin
                rd = rdata2; er = err2; lat = n;
                break;
            end
        end
        if (lat < 0) chk("req2_timeout", 32'(0), 32'(1));
        req2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_req0(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b);
        int n;
        bit seen;
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        n = 0; seen = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            seen = ready0;
        end
        if (!seen) chk("req0_timeout", 32'(0), 32'(1));
        req0 = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        int          t[3];
        logic [31:0] got[3];
        logic [31:0] ra[3];
        int          k, lowcnt, cyc;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(ready2), 32'(0));
        chk("rst_err", 32'(err2), 32'(0));
        chk("rst_busy", 32'(busy2), 32'(0));
        chk("rst_rdata", rdata2, 32'h0);
        chk("rst_busy0", 32'(busy0), 32'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // Write then read with latency
        do_req2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("wr10_lat", 32'(lat), 32'(4));
        chk("wr10_err", 32'(er), 32'(0));
        chk("wr10_rdata", rd, 32'h0);
        do_req2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("rd10_lat", 32'(lat), 32'(4));
        chk("rd10_data", rd, 32'hDEADBEEF);
        chk("rd10_err", 32'(er), 32'(0));

        // Byte lanes
        do_req2(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        do_req2(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        do_req2(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("lanes_data", rd, 32'h11BB33DD);
        do_req2(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        chk("be0_lat", 32'(lat), 32'(4));
        chk("be0_err", 32'(er), 32'(0));
        do_req2(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("be0_data", rd, 32'h11BB33DD);

        // Errors: misaligned and out of range
        do_req2(1'b1, 32'h13, 32'h55555555, 4'hF, rd, er, lat);
        chk("mis_err", 32'(er), 32'(1));
        chk("mis_rdata", rd, 32'h0);
        do_req2(1'b1, 32'h1000, 32'h66666666, 4'hF, rd, er, lat);
        chk("oor_err", 32'(er), 32'(1));
        chk("oor_rdata", rd, 32'h0);
        do_req2(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        chk("oor_rd_err", 32'(er), 32'(1));
        chk("oor_rd_rdata", rd, 32'h0);
        do_req2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("err_nowrite", rd, 32'hDEADBEEF);
        do_req2(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
        chk("last_word_err", 32'(er), 32'(0));

        // Reset during BUSY aborts a pending write
        do_req2(1'b1, 32'h40, 32'h0, 4'hF, rd, er, lat);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h40; wdata2 = 32'h12345678; be2 = 4'hF;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy2), 32'(1));
        #2 reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready2), 32'(0));
        chk("midrst_err", 32'(err2), 32'(0));
        chk("midrst_busy", 32'(busy2), 32'(0));
        chk("midrst_rdata", rdata2, 32'h0);
        req2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_req2(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        chk("abort_data", rd, 32'h0);
        do_req2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("persist_data", rd, 32'hDEADBEEF);

        // WAIT_CYCLES=0: back-to-back reads with req held high
        ra[0] = 32'h100; ra[1] = 32'h104; ra[2] = 32'h108;
        do_req0(1'b1, ra[0], 32'hA0A0A0A0, 4'hF);
        do_req0(1'b1, ra[1], 32'hB1B1B1B1, 4'hF);
        do_req0(1'b1, ra[2], 32'hC2C2C2C2, 4'hF);
        req0 = 1'b1; we0 = 1'b0; addr0 = ra[0];
        k = 0; lowcnt = 0; cyc = 0;
        t[0] = 0; t[1] = 0; t[2] = 0;
        got[0] = '0; got[1] = '0; got[2] = '0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk);
            cyc++;
            if (ready0) begin
                t[k] = cyc; got[k] = rdata0; k++;
                if (k < 3) addr0 = ra[k];
                else req0 = 1'b0;
            end else if (k >= 1 && !busy0) begin
                lowcnt++;
            end
        end
        chk("b2b_count", 32'(k), 32'(3));
        chk("b2b_gap1", 32'(t[1] - t[0]), 32'(3));
        chk("b2b_gap2", 32'(t[2] - t[1]), 32'(3));
        chk("b2b_idle", 32'(lowcnt), 32'(2));
        chk("b2b_d0", got[0], 32'hA0A0A0A0);
        chk("b2b_d1", got[1], 32'hB1B1B1B1);
        chk("b2b_d2", got[2], 32'hC2C2C2C2);
        @(negedge clk);
        chk("b2b_ready_drop", 32'(ready0), 32'(0));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wait_responder.md
# mem_wait_responder

Memory-side responder for the CPU's data/instruction memory port. It accepts one word-sized read or write request at a time over a req/ready handshake and inserts a configurable number of wait states. It applies byte-lane write enables and flags misaligned or out-of-range accesses. It replaces the zero-latency unified memory when the core is exercised against slow-memory timing.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: extra cycles spent in BUSY before the access is performed (0 allowed).

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request valid; requestor holds it and addr/we/wdata/be stable until ready.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address.
- wdata  input  32  write data; lane i = wdata[8i+7:8i].
- be  input  4  byte enables for writes; ignored on reads.
- rdata  output  32  read data, valid only while ready=1.
- ready  output  1  one-cycle completion pulse.
- err  output  1  access error, valid only while ready=1.
- busy  output  1  high when state is not IDLE.

## Operation
- State machine: IDLE, BUSY, RESP.
- IDLE: if req=1 at a clock edge, latch we, addr, wdata and be, load the wait counter with WAIT_CYCLES, and go to BUSY. If req=0, stay in IDLE.
- BUSY with counter != 0: decrement the counter. req and the inputs are not sampled; the latched copies are used.
- BUSY with counter == 0: perform the access and go to RESP.
- RESP: ready=1 for exactly one cycle, then go to IDLE unconditionally.
- Error check uses latched values. It is an error if addr[1:0] != 0 (misaligned) or addr[31:2] >= DEPTH_WORDS (out of range).
- Error access: no array write; rdata=0; err=1 during RESP.
- Read: rdata is the full word at addr[31:2].
- Write: only lanes with be[i]=1 are updated. be=4'b0000 is a legal no-op that still completes with ready. rdata=0 on writes.
- err, rdata and ready are registered outputs. busy decodes the state register.
- The memory array is not reset. Contents persist across reset.
- Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.

## Timing
- Reset (async, immediate): state=IDLE, counter=0, ready=0, err=0, rdata=0, busy=0.
- Reset during BUSY aborts the access. A pending write is discarded and the array is unchanged.
- Reset during RESP drops ready immediately.
- Latency: request accepted at edge E0. The access is performed at edge E0+WAIT_CYCLES+1. ready/err/rdata are high during the following cycle and are sampled by the requestor at edge E0+WAIT_CYCLES+2.
- After ready, the requestor deasserts req or presents the next request. req held high is re-accepted in IDLE at edge E0+WAIT_CYCLES+3. Peak throughput is one access per WAIT_CYCLES+3 cycles.
- A write followed by a read of the same address returns the new data; there is no hazard because accesses are serialized.
- req changing while in BUSY/RESP has no effect. Dropping req before ready is a protocol violation; the access still completes.

## Test plan
- Write then read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10. Required: rdata=0xDEADBEEF, err=0, and ready sampled exactly 4 edges after each accepting edge.
- Byte lanes: with word 0x20 = 0x11223344, write 0xAABBCCDD with be=4'b0101, then read. Required: 0x11BB33DD. A write with be=0 leaves 0x11BB33DD unchanged and still gets ready.
- Errors, DEPTH_WORDS=1024: write to 0x13 and write to 0x1000. Required: ready=1, err=1, rdata=0, array unchanged (readback of 0x10 still 0xDEADBEEF).
- Reset mid-operation: issue a write of 0x12345678 to 0x40 (prior value 0). Assert reset while busy=1 in BUSY. Required: ready, err, busy and rdata all 0 immediately; a later read of 0x40 returns 0.
- WAIT_CYCLES=0 back-to-back: hold req high across 3 reads. Required: ready pulses exactly 3 cycles apart, each 1 cycle wide, busy low for exactly 1 cycle between accesses.
